uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the processor's data-memory bus, directly downstream of the datapath. Decodes the store bus the datapath drives (MemWrite, ALUResult as address, WriteData) and pushes bytes into a small FIFO. An FSM serializes them as 8N1 frames on `tx`. A status word is returned for loads so software can poll before writing; the top level muxes `RD` into the load path when `hit` is high.

---
 rtl/uart_tx_mmio.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: store-bus decode, byte FIFO, serializer FSM
// and a pollable status word for the load path.
`timescale 1ns/1ps
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = 32'h0000_0400,
    parameter logic [31:0] STATUS_ADDR  = 32'h0000_0404
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic sel_tx_s, sel_status_s, full_s, empty_s;
    logic push_req_s, push_s, pop_s, ovf_set_s, ovf_clr_s, baud_last_s;
    logic [7:0] count_ext_s;
    logic unused_wd_s;

    assign sel_tx_s     = (ADDR == TX_ADDR);
    assign sel_status_s = (ADDR == STATUS_ADDR);
    assign full_s       = (count_q == DEPTH_C);
    assign empty_s      = (count_q == {CNT_W{1'b0}});
    assign pop_s        = (state_q == IDLE) && !empty_s;
    assign push_req_s   = WE && sel_tx_s;
    // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
    assign push_s       = push_req_s && (!full_s || pop_s);
    assign ovf_set_s    = push_req_s && !push_s;
    assign ovf_clr_s    = WE && sel_status_s && WD[0];
    assign baud_last_s  = (baud_q == BAUD_LAST);
    assign count_ext_s  = 8'(count_q);
    assign unused_wd_s  = ^WD[31:8];

    assign hit  = sel_tx_s || sel_status_s;
    assign tx   = tx_q;
    assign busy = busy_q;

    // Status word decode for the load path
    always_comb begin
        RD = 32'h0000_0000;
        if (sel_status_s) begin
            RD = {16'h0000, count_ext_s, 4'h0, ovf_q, busy_q, empty_s, full_s};
        end else begin
            RD = 32'h0000_0000;
        end
    end

    // FIFO pointer, occupancy and overflow-flag next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Serializer next state; tx is computed one edge ahead so it leaves a flop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop_s) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_last_s) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    baud_d  = {BAUD_W{1'b0}};
                    tx_d    = shift_q[0];
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_last_s) begin
                    state_d = IDLE;
                    baud_d  = {BAUD_W{1'b0}};
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= WD[7:0];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            baud_q   <= {BAUD_W{1'b0}};
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] TXA   = 32'h0000_0400;
    localparam logic [31:0] STA   = 32'h0000_0404;
    localparam int          FRAME = 10 * CPB;
    localparam int          SLOT  = FRAME + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        hit;
    logic        tx;
    logic        busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .TX_ADDR     (TXA),
        .STATUS_ADDR (STA)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .WE   (WE),
        .ADDR (ADDR),
        .WD   (WD),
        .RD   (RD),
        .hit  (hit),
        .tx   (tx),
        .busy (busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tx m edges after the popping edge (m=0 is the first start-bit cycle).
    function automatic logic exp_tx(input logic [7:0] b, input int m);
        if (m < CPB) return 1'b0;
        else if (m < 9 * CPB) return b[(m - CPB) / CPB];
        else return 1'b1;
    endfunction

    initial begin
        int bad;
        int mt, j, m;
        logic etx, ebusy;

        vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0400, 32'h0000_00FF, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'h0000_0404, 32'h0000_0000, 1'b1, 32'h0000_0002};
        vecs[3] = '{1'b1, 32'h0000_0408, 32'h0000_0077, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h0000_03FC, 32'h0000_0012, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0000_0404, 32'h0000_0000, 1'b1, 32'h0000_0002};
        vecs[6] = '{1'b0, 32'h0000_0405, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'h0000_1400, 32'h0000_0033, 1'b0, 32'h0000_0000};

        reset = 1'b1; WE = 1'b0; ADDR = 32'h0; WD = 32'h0;
        tick(); tick();
        reset = 1'b0;
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hit", 32'(hit), 32'h0);
        ADDR = STA; #1;
        check("rst_status", RD, 32'h0000_0002);

        // Decode table: combinational hit/RD, then no side effect one edge later
        for (int i = 0; i < 8; i++) begin
            WE = vecs[i].we; ADDR = vecs[i].addr; WD = vecs[i].wd;
            #1;
            check($sformatf("dec_hit[%0d]", i), 32'(hit), 32'(vecs[i].exp_hit));
            check($sformatf("dec_rd[%0d]", i), RD, vecs[i].exp_rd);
            tick();
            WE = 1'b0; ADDR = STA; #1;
            check($sformatf("dec_status[%0d]", i), RD, 32'h0000_0002);
            check($sformatf("dec_tx[%0d]", i), 32'(tx), 32'h1);
        end

        // Single byte 0x55, upper WD bits ignored
        WE = 1'b1; ADDR = TXA; WD = 32'hFFFF_FF55;
        tick();
        WE = 1'b0; ADDR = STA; #1;
        check("push_status", RD, 32'h0000_0100);
        for (int n = 1; n <= SLOT; n++) begin
            tick();
            if (n == 1) check("pop_status", RD, 32'h0000_0006);
            if (n <= FRAME) begin
                check($sformatf("single_tx[%0d]", n), 32'(tx), 32'(exp_tx(8'h55, n - 1)));
                check($sformatf("single_busy[%0d]", n), 32'(busy), 32'h1);
            end else begin
                check("single_idle_tx", 32'(tx), 32'h1);
                check("single_idle_busy", 32'(busy), 32'h0);
            end
        end

        // Overflow: 10 stores on consecutive edges, then nine frames back to back
        for (int t = 0; t <= 9 * SLOT + 6; t++) begin
            if (t < 10) begin
                WE = 1'b1; ADDR = TXA; WD = 32'(t);
            end else begin
                WE = 1'b0; ADDR = STA;
            end
            tick();
            if (t == 9) begin
                WE = 1'b0; ADDR = STA; #1;
                check("ovf_status", RD, 32'h0000_080D);
            end
            if (t >= 1) begin
                mt = t - 1; j = mt / SLOT; m = mt % SLOT;
                if (j < 9) begin
                    etx = exp_tx(8'(j), m);
                    ebusy = (m < FRAME);
                end else begin
                    etx = 1'b1;
                    ebusy = 1'b0;
                end
                check($sformatf("ovf_tx[t=%0d]", t), 32'(tx), 32'(etx));
                check($sformatf("ovf_busy[t=%0d]", t), 32'(busy), 32'(ebusy));
            end
        end
        ADDR = STA; #1;
        check("ovf_sticky", RD, 32'h0000_000A);

        WE = 1'b1; ADDR = STA; WD = 32'h0;
        tick();
        WE = 1'b0; #1;
        check("ovf_clr0_keeps", RD, 32'h0000_000A);
        WE = 1'b1; WD = 32'h1;
        tick();
        WE = 1'b0; #1;
        check("ovf_clr1", RD, 32'h0000_0002);

        // Reset during data bit 3 with three bytes queued
        WE = 1'b1; ADDR = TXA; WD = 32'hA5;
        tick();
        WD = 32'h3C; tick();
        WD = 32'h81; tick();
        WE = 1'b0; ADDR = STA;
        for (int n = 0; n < 14; n++) tick();
        check("mid_bit2", 32'(tx), 32'h1);
        tick();
        check("mid_bit3", 32'(tx), 32'h0);
        check("mid_busy", 32'(busy), 32'h1);
        check("mid_status", RD, 32'h0000_0204);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_tx", 32'(tx), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_status", RD, 32'h0000_0002);
        bad = 0;
        for (int n = 0; n < 3 * SLOT; n++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_no_frames", 32'(bad), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
